// File: rtl/fwd_pkg.sv
// Shared constants for the forwarding / load-use hazard unit.
package fwd_pkg;
  // One-hot ALU operand select width and encodings
  localparam int SEL_W = 5;
  localparam logic [SEL_W-1:0] SEL_ID_EX     = 5'b00001;
  localparam logic [SEL_W-1:0] SEL_EXMEM_TOP = 5'b00010;
  localparam logic [SEL_W-1:0] SEL_EXMEM_BOT = 5'b00100;
  localparam logic [SEL_W-1:0] SEL_MEMWB_TOP = 5'b01000;
  localparam logic [SEL_W-1:0] SEL_MEMWB_BOT = 5'b10000;

  // Default slot field widths
  localparam int REG_ADDR_W_DEF  = 5;
  localparam int STALL_CNT_W_DEF = 16;

  // Number of ALU source operands (top, bottom)
  localparam int NUM_SRC = 2;
endpackage

// File: rtl/fwd_src_select.sv
// Per-source forwarding select and load-use detection against EX/MEM slots.
module fwd_src_select
  import fwd_pkg::*;
#(
  parameter int REG_ADDR_W = REG_ADDR_W_DEF
) (
  input  logic [REG_ADDR_W-1:0] i_src,
  input  logic                  i_src_en,
  input  logic                  i_ex_valid,
  input  logic                  i_ex_is_load,
  input  logic [REG_ADDR_W-1:0] i_ex_dst_top,
  input  logic                  i_ex_wr_top,
  input  logic [REG_ADDR_W-1:0] i_ex_dst_bot,
  input  logic                  i_ex_wr_bot,
  input  logic                  i_mem_valid,
  input  logic [REG_ADDR_W-1:0] i_mem_dst_top,
  input  logic                  i_mem_wr_top,
  input  logic [REG_ADDR_W-1:0] i_mem_dst_bot,
  input  logic                  i_mem_wr_bot,
  output logic [SEL_W-1:0]      o_sel,
  output logic                  o_load_hit
);
  logic w_ex_top_hit, w_ex_bot_hit, w_mem_top_hit, w_mem_bot_hit;

  // Raw tag matches; an invalid slot never matches
  assign w_ex_top_hit  = i_src_en & i_ex_valid  & i_ex_wr_top  & (i_ex_dst_top  == i_src);
  assign w_ex_bot_hit  = i_src_en & i_ex_valid  & i_ex_wr_bot  & (i_ex_dst_bot  == i_src);
  assign w_mem_top_hit = i_src_en & i_mem_valid & i_mem_wr_top & (i_mem_dst_top == i_src);
  assign w_mem_bot_hit = i_src_en & i_mem_valid & i_mem_wr_bot & (i_mem_dst_bot == i_src);

  // A load in EX has no result yet: it cannot forward, it forces a stall
  assign o_load_hit = i_ex_is_load & (w_ex_top_hit | w_ex_bot_hit);

  // Priority: newer slot first, top destination before bottom
  always_comb begin
    o_sel = SEL_ID_EX;
    if (!i_src_en)                         o_sel = SEL_ID_EX;
    else if (w_ex_top_hit && !i_ex_is_load) o_sel = SEL_EXMEM_TOP;
    else if (w_ex_bot_hit && !i_ex_is_load) o_sel = SEL_EXMEM_BOT;
    else if (w_mem_top_hit)                o_sel = SEL_MEMWB_TOP;
    else if (w_mem_bot_hit)                o_sel = SEL_MEMWB_BOT;
    else                                   o_sel = SEL_ID_EX;
  end
endmodule

// File: rtl/fwd_hazard_unit.sv
// ID-stage forwarding select generator and load-use stall unit.
module fwd_hazard_unit
  import fwd_pkg::*;
#(
  parameter int REG_ADDR_W  = REG_ADDR_W_DEF,
  parameter int STALL_CNT_W = STALL_CNT_W_DEF
) (
  input  logic                   i_clock,
  input  logic                   i_reset,
  input  logic                   i_freeze,
  input  logic                   i_flush,
  input  logic                   i_id_valid,
  input  logic [REG_ADDR_W-1:0]  i_id_src_top,
  input  logic [REG_ADDR_W-1:0]  i_id_src_bot,
  input  logic                   i_id_src_top_en,
  input  logic                   i_id_src_bot_en,
  input  logic [REG_ADDR_W-1:0]  i_id_dst_top,
  input  logic [REG_ADDR_W-1:0]  i_id_dst_bot,
  input  logic                   i_id_wr_top,
  input  logic                   i_id_wr_bot,
  input  logic                   i_id_is_load,
  output logic [SEL_W-1:0]       o_alu_input_sel_top,
  output logic [SEL_W-1:0]       o_alu_input_sel_bot,
  output logic                   o_stall,
  output logic [STALL_CNT_W-1:0] o_stall_count
);
  // EX slot
  logic                  r_ex_valid, r_ex_wr_top, r_ex_wr_bot, r_ex_is_load;
  logic [REG_ADDR_W-1:0] r_ex_dst_top, r_ex_dst_bot;
  // MEM slot
  logic                  r_mem_valid, r_mem_wr_top, r_mem_wr_bot;
  logic [REG_ADDR_W-1:0] r_mem_dst_top, r_mem_dst_bot;

  logic [SEL_W-1:0]       r_sel_top, r_sel_bot;
  logic [STALL_CNT_W-1:0] r_stall_cnt;

  // Index 0 = top operand, 1 = bottom operand
  logic [NUM_SRC-1:0][REG_ADDR_W-1:0] w_src;
  logic [NUM_SRC-1:0]                 w_src_en;
  logic [NUM_SRC-1:0][SEL_W-1:0]      w_sel;
  logic [NUM_SRC-1:0]                 w_load_hit;
  logic                               w_hazard, w_issue;

  assign w_src    = {i_id_src_bot, i_id_src_top};
  assign w_src_en = {i_id_src_bot_en, i_id_src_top_en};

  genvar g;
  generate
    for (g = 0; g < NUM_SRC; g++) begin : g_src
      fwd_src_select #(.REG_ADDR_W(REG_ADDR_W)) u_sel (
        .i_src        (w_src[g]),
        .i_src_en     (w_src_en[g]),
        .i_ex_valid   (r_ex_valid),
        .i_ex_is_load (r_ex_is_load),
        .i_ex_dst_top (r_ex_dst_top),
        .i_ex_wr_top  (r_ex_wr_top),
        .i_ex_dst_bot (r_ex_dst_bot),
        .i_ex_wr_bot  (r_ex_wr_bot),
        .i_mem_valid  (r_mem_valid),
        .i_mem_dst_top(r_mem_dst_top),
        .i_mem_wr_top (r_mem_wr_top),
        .i_mem_dst_bot(r_mem_dst_bot),
        .i_mem_wr_bot (r_mem_wr_bot),
        .o_sel        (w_sel[g]),
        .o_load_hit   (w_load_hit[g])
      );
    end
  endgenerate

  // A flushed consumer is squashed anyway, so it never stalls
  assign w_hazard = i_id_valid & (|w_load_hit);
  assign o_stall  = w_hazard & ~i_flush;
  assign w_issue  = i_id_valid & ~o_stall & ~i_flush;

  // Slot pipeline and registered operand selects
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_ex_valid    <= 1'b0;
      r_ex_wr_top   <= 1'b0;
      r_ex_wr_bot   <= 1'b0;
      r_ex_is_load  <= 1'b0;
      r_ex_dst_top  <= '0;
      r_ex_dst_bot  <= '0;
      r_mem_valid   <= 1'b0;
      r_mem_wr_top  <= 1'b0;
      r_mem_wr_bot  <= 1'b0;
      r_mem_dst_top <= '0;
      r_mem_dst_bot <= '0;
      r_sel_top     <= SEL_ID_EX;
      r_sel_bot     <= SEL_ID_EX;
    end else if (!i_freeze) begin
      r_mem_valid   <= r_ex_valid;
      r_mem_wr_top  <= r_ex_wr_top;
      r_mem_wr_bot  <= r_ex_wr_bot;
      r_mem_dst_top <= r_ex_dst_top;
      r_mem_dst_bot <= r_ex_dst_bot;
      if (w_issue) begin
        r_ex_valid   <= 1'b1;
        r_ex_wr_top  <= i_id_wr_top;
        r_ex_wr_bot  <= i_id_wr_bot;
        r_ex_is_load <= i_id_is_load;
        r_ex_dst_top <= i_id_dst_top;
        r_ex_dst_bot <= i_id_dst_bot;
        r_sel_top    <= w_sel[0];
        r_sel_bot    <= w_sel[1];
      end else begin
        r_ex_valid <= 1'b0;
        r_sel_top  <= SEL_ID_EX;
        r_sel_bot  <= SEL_ID_EX;
      end
    end
  end

  // Saturating stall-cycle counter; frozen cycles are not counted
  always_ff @(posedge i_clock) begin
    if (i_reset)
      r_stall_cnt <= '0;
    else if (!i_freeze && o_stall && !(&r_stall_cnt))
      r_stall_cnt <= r_stall_cnt + 1'b1;
  end

  assign o_alu_input_sel_top = r_sel_top;
  assign o_alu_input_sel_bot = r_sel_bot;
  assign o_stall_count       = r_stall_cnt;
endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Directed bench for fwd_hazard_unit with hand-computed expectations.
module tb_fwd_hazard_unit;
  logic        clk = 1'b0;
  logic        reset, freeze, flush, id_valid;
  logic [4:0]  src_top, src_bot, dst_top, dst_bot;
  logic        src_top_en, src_bot_en, wr_top, wr_bot, is_load;
  logic [4:0]  sel_top, sel_bot;
  logic        stall;
  logic [15:0] stall_count;

  int total = 0;
  int passed = 0;

  fwd_hazard_unit #(.REG_ADDR_W(5), .STALL_CNT_W(16)) dut (
    .i_clock            (clk),
    .i_reset            (reset),
    .i_freeze           (freeze),
    .i_flush            (flush),
    .i_id_valid         (id_valid),
    .i_id_src_top       (src_top),
    .i_id_src_bot       (src_bot),
    .i_id_src_top_en    (src_top_en),
    .i_id_src_bot_en    (src_bot_en),
    .i_id_dst_top       (dst_top),
    .i_id_dst_bot       (dst_bot),
    .i_id_wr_top        (wr_top),
    .i_id_wr_bot        (wr_bot),
    .i_id_is_load       (is_load),
    .o_alu_input_sel_top(sel_top),
    .o_alu_input_sel_bot(sel_bot),
    .o_stall            (stall),
    .o_stall_count      (stall_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
  endtask

  // Advance one clock; leave time 1 unit past the edge for sampling
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    id_valid = 0; src_top_en = 0; src_bot_en = 0; wr_top = 0; wr_bot = 0;
    is_load = 0; src_top = 0; src_bot = 0; dst_top = 0; dst_bot = 0;
  endtask

  task automatic issue(input logic [4:0] st, input logic ste, input logic [4:0] sb, input logic sbe,
                       input logic [4:0] dt, input logic wt, input logic [4:0] db, input logic wb,
                       input logic ld);
    id_valid = 1; src_top = st; src_top_en = ste; src_bot = sb; src_bot_en = sbe;
    dst_top = dt; wr_top = wt; dst_bot = db; wr_bot = wb; is_load = ld;
  endtask

  initial begin
    reset = 1; freeze = 0; flush = 0;
    idle();
    // Reset held two cycles, released with no traffic
    step(); step();
    reset = 0;
    step();
    chk("rst_sel_top", sel_top, 5'b00001);
    chk("rst_sel_bot", sel_bot, 5'b00001);
    chk("rst_stall",   stall, 1'b0);
    chk("rst_count",   stall_count, 16'd0);

    // Distance-1 forward: writer of r3 (top), reader of r3 on both sources
    issue(0,0, 0,0, 3,1, 0,0, 0); step();
    issue(3,1, 3,1, 0,0, 0,0, 0);
    #1 chk("d1_no_stall", stall, 1'b0);
    step();
    chk("d1_sel_top", sel_top, 5'b00010);
    chk("d1_sel_bot", sel_bot, 5'b00010);
    idle(); step();
    chk("bubble_sel_top", sel_top, 5'b00001);
    step();

    // Distance-2 forward from MEM/WB bottom
    issue(0,0, 0,0, 0,0, 5,1, 0); step();
    issue(1,1, 0,0, 9,1, 0,0, 0); step();
    issue(5,1, 6,1, 0,0, 0,0, 0); step();
    chk("d2_sel_top", sel_top, 5'b10000);
    chk("d2_sel_bot", sel_bot, 5'b00001);
    idle(); step(); step();

    // Load-use: one-cycle stall, bubble, then MEM/WB top forward
    issue(0,0, 0,0, 7,1, 0,0, 1); step();
    issue(7,1, 0,0, 0,0, 0,0, 0);
    #1 chk("lu_stall", stall, 1'b1);
    step();
    chk("lu_bubble_sel", sel_top, 5'b00001);
    chk("lu_count", stall_count, 16'd1);
    chk("lu_stall_one_cycle", stall, 1'b0);
    step();
    chk("lu_fwd_sel", sel_top, 5'b01000);
    chk("lu_count_hold", stall_count, 16'd1);
    idle(); step(); step();

    // Load-use with flush in the same cycle
    issue(0,0, 0,0, 7,1, 0,0, 1); step();
    issue(7,1, 0,0, 0,0, 0,0, 0);
    flush = 1;
    #1 chk("flush_stall", stall, 1'b0);
    step();
    flush = 0;
    chk("flush_sel", sel_top, 5'b00001);
    chk("flush_count", stall_count, 16'd1);
    idle(); step(); step();

    // Freeze for three cycles mid-sequence
    issue(0,0, 0,0, 4,1, 0,0, 0); step();
    issue(0,0, 4,1, 0,0, 0,0, 0); step();
    chk("frz_pre_sel_bot", sel_bot, 5'b00010);
    issue(4,1, 0,0, 0,0, 0,0, 0);
    freeze = 1;
    step(); step(); step();
    chk("frz_sel_top", sel_top, 5'b00001);
    chk("frz_sel_bot", sel_bot, 5'b00010);
    freeze = 0;
    step();
    chk("frz_resume_sel_top", sel_top, 5'b01000);
    idle(); step(); step();

    // Load-use stall visible during freeze but not counted
    issue(0,0, 0,0, 7,1, 0,0, 1); step();
    issue(0,0, 7,1, 0,0, 0,0, 0);
    freeze = 1;
    #1 chk("frz_stall_visible", stall, 1'b1);
    step(); step();
    chk("frz_count_hold", stall_count, 16'd1);
    freeze = 0;
    step();
    chk("frz_lu_count", stall_count, 16'd2);
    step();
    chk("frz_lu_fwd_bot", sel_bot, 5'b01000);
    idle(); step(); step();

    // EX beats MEM, top beats bottom, then an EX/MEM bottom forward
    issue(0,0, 0,0, 0,0, 2,1, 0); step();
    issue(0,0, 0,0, 2,1, 2,1, 0); step();
    issue(2,1, 2,1, 0,0, 8,1, 0); step();
    chk("prio_sel_top", sel_top, 5'b00010);
    chk("prio_sel_bot", sel_bot, 5'b00010);
    issue(8,1, 2,1, 0,0, 0,0, 0); step();
    chk("exbot_sel_top", sel_top, 5'b00100);
    chk("mem_top_sel_bot", sel_bot, 5'b01000);
    idle(); step(); step();

    // Reset mid-stream with a pending load-use hazard
    issue(0,0, 0,0, 7,1, 0,0, 1); step();
    issue(7,1, 0,0, 0,0, 0,0, 0);
    #1 chk("mid_rst_pre_stall", stall, 1'b1);
    reset = 1;
    step();
    reset = 0;
    chk("mid_rst_stall", stall, 1'b0);
    chk("mid_rst_sel_top", sel_top, 5'b00001);
    chk("mid_rst_count", stall_count, 16'd0);
    step();
    chk("mid_rst_tags_gone", sel_top, 5'b00001);
    idle(); step();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/fwd_hazard_unit.md
Name: fwd_hazard_unit

Overview:
- Forwarding and load-use hazard unit in the ID stage of the 8-bit pipeline.
- Tracks destination tags of in-flight instructions in the EX and MEM slots.
- Computes one-hot ALU operand selects for the instruction leaving ID and registers them, so they are valid while that instruction is in EX and drive the ALU operand input multiplexer.
- Raises a one-cycle stall on load-use hazards and counts stall cycles.

Parameters:
- REG_ADDR_W, 5, register-file address width.
- STALL_CNT_W, 16, width of the saturating stall counter.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high.
- freeze  in  1  global pipeline hold (memory wait); all state holds.
- flush  in  1  squash instruction in ID (taken branch).
- id_valid  in  1  ID holds a real instruction.
- id_src_top / id_src_bot  in  REG_ADDR_W  source register addresses.
- id_src_top_en / id_src_bot_en  in  1  source is actually read.
- id_dst_top / id_dst_bot  in  REG_ADDR_W  destination addresses.
- id_wr_top / id_wr_bot  in  1  destination is written.
- id_is_load  in  1  result exists only after MEM (MEM/WB top/bot).
- alu_input_sel_top  out  5  registered one-hot select, top operand.
- alu_input_sel_bot  out  5  registered one-hot select, bottom operand.
- stall  out  1  combinational; hold PC and IF/ID, insert bubble into EX.
- stall_count  out  STALL_CNT_W  saturating count of stall cycles.

Behaviour:
- Select encoding: 00001 ID/EX register data; 00010 EX/MEM top; 00100 EX/MEM bottom; 01000 MEM/WB top; 10000 MEM/WB bottom. The encoding is always exactly one-hot; never drive 00000.
- Internal state:
  - EX slot {valid, dst_top, wr_top, dst_bot, wr_bot, is_load}.
  - MEM slot {valid, dst_top, wr_top, dst_bot, wr_bot}.
- Per-source select, evaluated in priority order (first match wins):
  1. Source not enabled -> 00001.
  2. EX slot valid, not a load, and wr_top with dst_top match -> 00010.
  3. EX slot match via wr_bot/dst_bot -> 00100.
  4. MEM slot wr_top match -> 01000.
  5. MEM slot wr_bot match -> 10000.
  6. Otherwise -> 00001.
- Top beats bottom when both destinations of one slot are equal. The EX slot (newer) beats the MEM slot.
- Load-use: hazard = id_valid & EX.valid & EX.is_load & (enabled source matches EX dst_top with wr_top, or EX dst_bot with wr_bot).
- stall = hazard & ~flush.
- Rising edge, reset=1:
  - Both slots become invalid.
  - Both selects become 00001.
  - stall_count becomes 0.
  - stall reads 0 on the following cycle.
  - Reset mid-operation discards all tracked tags immediately.
- Rising edge, freeze=1: all registers hold and stall_count does not increment. stall still reflects current inputs.
- Rising edge, normal (reset=0, freeze=0):
  - MEM slot <= EX slot.
  - If id_valid & ~stall & ~flush: EX slot <= ID tags, selects <= computed values.
  - Otherwise: EX slot valid <= 0 and selects <= 00001 (bubble).
  - stall_count increments when stall=1, saturating at all-ones.
- Latency: selects appear 1 cycle after the consumer sits in ID. This covers producer distances of 1 (EX/MEM) and 2 (MEM/WB).
- At distance 3 or more the register file is write-through, so no forwarding path is needed.
- Load-use stall lasts exactly one cycle. On the next cycle the load occupies the MEM slot and the consumer receives 01000/10000.
- Flush with hazard present: stall=0, bubble enters EX, no count.
- A bubble or invalid slot never matches any source.
- Register 0 has no special treatment; the decoder clears wr_* for it.

Decomposition:
- Shared package fwd_pkg:
  - SEL_ID_EX, SEL_EXMEM_TOP, SEL_EXMEM_BOT, SEL_MEMWB_TOP, SEL_MEMWB_BOT constants.
  - SEL_W=5.
  - Slot field widths.
- Sub-module fwd_src_select: one source address and enable plus both slots in, 5-bit one-hot select and a load-hit flag out. Instantiated twice, once for top and once for bottom.

Test Plan:
- Reset held 2 cycles, then release with no traffic -> selects 00001/00001, stall 0, stall_count 0.
- ALU op writes r3 (top), next op reads r3 as both top and bottom sources -> consumer's EX cycle shows sel_top=00010, sel_bot=00010.
- Op writes r5 via bottom destination, unrelated op, then an op reading r5 as top -> sel_top=10000.
- Load to r7, immediately followed by an op reading r7 -> stall=1 for exactly 1 cycle, stall_count=1, bubble selects 00001, then sel=01000.
- Load-use hazard with flush=1 in the same cycle -> stall=0, count unchanged. freeze=1 for 3 cycles mid-sequence -> selects and slots unchanged, then forwarding resumes correctly.
- EX and MEM slots both write r2, consumer reads r2 -> 00010, the EX slot wins. Reset asserted mid-stream with a pending hazard -> next cycle stall=0 and selects 00001.
